// File: rtl/chroma_pkg.sv
// Shared mode encodings and FSM state type for the chroma-key pipeline.
package chroma_pkg;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_COMPOSITE = 2'd1;
    localparam logic [1:0] MODE_MATTE     = 2'd2;
    localparam logic [1:0] MODE_BGONLY    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } chromaState_t;

endpackage

// File: rtl/chroma_key_compare.sv
// Combinational green-screen key decision and output colour select.
module chroma_key_compare
    import chroma_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    input  logic [DW-1:0] iBgRed,
    input  logic [DW-1:0] iBgGreen,
    input  logic [DW-1:0] iBgBlue,
    input  logic [1:0]    iMode,
    input  logic [DW-1:0] iKeyGMin,
    input  logic [DW-1:0] iKeyRMargin,
    input  logic [DW-1:0] iKeyBMargin,
    output logic [DW-1:0] oRed_c,
    output logic [DW-1:0] oGreen_c,
    output logic [DW-1:0] oBlue_c,
    output logic          oKey_c
);

    localparam int unsigned SW = DW + 1;

    logic [SW-1:0] rLimit;
    logic [SW-1:0] bLimit;

    always_comb begin
        rLimit   = SW'(iRed) + SW'(iKeyRMargin);
        bLimit   = SW'(iBlue) + SW'(iKeyBMargin);
        oKey_c   = (iGreen >= iKeyGMin) && (SW'(iGreen) >= rLimit) && (SW'(iGreen) >= bLimit);
        oRed_c   = iRed;
        oGreen_c = iGreen;
        oBlue_c  = iBlue;
        case (iMode)
            MODE_COMPOSITE: begin
                if (oKey_c) begin
                    oRed_c   = iBgRed;
                    oGreen_c = iBgGreen;
                    oBlue_c  = iBgBlue;
                end
            end
            MODE_MATTE: begin
                oRed_c   = oKey_c ? '1 : '0;
                oGreen_c = oKey_c ? '1 : '0;
                oBlue_c  = oKey_c ? '1 : '0;
            end
            MODE_BGONLY: begin
                oRed_c   = iBgRed;
                oGreen_c = iBgGreen;
                oBlue_c  = iBgBlue;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/chroma_key_pipeline.sv
// Three-stage chroma-key pipeline: capture, key/mix, output, with frame
// tracking, pixel position and per-frame keyed-pixel statistics.
module chroma_key_pipeline
    import chroma_pkg::*;
#(
    parameter int unsigned DW = 10,
    parameter int unsigned XW = 12,
    parameter int unsigned YW = 11,
    parameter int unsigned CW = 20
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    input  logic [DW-1:0] iBgRed,
    input  logic [DW-1:0] iBgGreen,
    input  logic [DW-1:0] iBgBlue,
    input  logic [1:0]    iMode,
    input  logic [DW-1:0] iKeyGMin,
    input  logic [DW-1:0] iKeyRMargin,
    input  logic [DW-1:0] iKeyBMargin,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic          oDVAL,
    output logic          oFVAL,
    output logic          oKeyMask,
    output logic [XW-1:0] oX_Counter,
    output logic [YW-1:0] oY_Counter,
    output logic [CW-1:0] oKeyCount,
    output logic [31:0]   oFrame_Counter
);

    localparam logic [CW-1:0] KEY_MAX = '1;

    chromaState_t  state;
    logic          fvalPrev, dvalPrev;
    logic [1:0]    shMode;
    logic [DW-1:0] shBgRed, shBgGreen, shBgBlue, shGMin, shRMargin, shBMargin;
    logic [XW-1:0] xCnt, aX, bX;
    logic [YW-1:0] yCnt, aY, bY;
    logic          aValid, aStart, aEnd, aFval;
    logic          bValid, bStart, bEnd, bFval, bKey;
    logic [DW-1:0] aRed, aGreen, aBlue, bRed, bGreen, bBlue;
    logic [CW-1:0] keyCnt;
    logic [DW-1:0] mixRed_c, mixGreen_c, mixBlue_c;
    logic          key_c;
    logic          frameStart_c, frameEnd_c, pixValid_c, lineEnd_c;

    // A rising edge only opens a frame once a low iFVAL has been seen since reset.
    assign frameStart_c = (state == WAIT_SOF) && iFVAL && !fvalPrev;
    assign frameEnd_c   = (state == ACTIVE) && !iFVAL && fvalPrev;
    assign pixValid_c   = iFVAL && iDVAL && ((state == ACTIVE) || frameStart_c);
    assign lineEnd_c    = (state == ACTIVE) && dvalPrev && !pixValid_c;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            shMode    <= MODE_PASS;
            shBgRed   <= '0;
            shBgGreen <= '0;
            shBgBlue  <= '0;
            shGMin    <= '0;
            shRMargin <= '0;
            shBMargin <= '0;
        end else begin
            case (state)
                IDLE:     if (!iFVAL) state <= WAIT_SOF;
                WAIT_SOF: begin
                    if (frameStart_c) begin
                        state     <= ACTIVE;
                        shMode    <= iMode;
                        shBgRed   <= iBgRed;
                        shBgGreen <= iBgGreen;
                        shBgBlue  <= iBgBlue;
                        shGMin    <= iKeyGMin;
                        shRMargin <= iKeyRMargin;
                        shBMargin <= iKeyBMargin;
                    end
                end
                ACTIVE:   if (frameEnd_c) state <= WAIT_SOF;
                default:  state <= IDLE;
            endcase
        end
    end

    // Capture stage: stamps each valid pixel with its frame position.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fvalPrev <= 1'b0;
            dvalPrev <= 1'b0;
            aValid   <= 1'b0;
            aStart   <= 1'b0;
            aEnd     <= 1'b0;
            aFval    <= 1'b0;
            aRed     <= '0;
            aGreen   <= '0;
            aBlue    <= '0;
            aX       <= '0;
            aY       <= '0;
            xCnt     <= '0;
            yCnt     <= '0;
        end else begin
            fvalPrev <= iFVAL;
            dvalPrev <= pixValid_c;
            aValid   <= pixValid_c;
            aStart   <= frameStart_c;
            aEnd     <= frameEnd_c;
            aFval    <= iFVAL;
            aRed     <= iRed;
            aGreen   <= iGreen;
            aBlue    <= iBlue;
            if (frameStart_c) begin
                aX   <= '0;
                aY   <= '0;
                xCnt <= XW'(pixValid_c);
                yCnt <= '0;
            end else begin
                aX <= xCnt;
                aY <= yCnt;
                if (pixValid_c) begin
                    xCnt <= xCnt + XW'(1);
                end else if (lineEnd_c) begin
                    xCnt <= '0;
                    yCnt <= yCnt + YW'(1);
                end
            end
        end
    end

    chroma_key_compare #(.DW(DW)) uCompare (
        .iRed        (aRed),
        .iGreen      (aGreen),
        .iBlue       (aBlue),
        .iBgRed      (shBgRed),
        .iBgGreen    (shBgGreen),
        .iBgBlue     (shBgBlue),
        .iMode       (shMode),
        .iKeyGMin    (shGMin),
        .iKeyRMargin (shRMargin),
        .iKeyBMargin (shBMargin),
        .oRed_c      (mixRed_c),
        .oGreen_c    (mixGreen_c),
        .oBlue_c     (mixBlue_c),
        .oKey_c      (key_c)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bValid <= 1'b0;
            bStart <= 1'b0;
            bEnd   <= 1'b0;
            bFval  <= 1'b0;
            bKey   <= 1'b0;
            bRed   <= '0;
            bGreen <= '0;
            bBlue  <= '0;
            bX     <= '0;
            bY     <= '0;
        end else begin
            bValid <= aValid;
            bStart <= aStart;
            bEnd   <= aEnd;
            bFval  <= aFval;
            bKey   <= key_c;
            bRed   <= mixRed_c;
            bGreen <= mixGreen_c;
            bBlue  <= mixBlue_c;
            bX     <= aX;
            bY     <= aY;
        end
    end

    // Output stage; frame statistics move in step with the delayed frame.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRed           <= '0;
            oGreen         <= '0;
            oBlue          <= '0;
            oDVAL          <= 1'b0;
            oFVAL          <= 1'b0;
            oKeyMask       <= 1'b0;
            oX_Counter     <= '0;
            oY_Counter     <= '0;
            oKeyCount      <= '0;
            oFrame_Counter <= '0;
            keyCnt         <= '0;
        end else begin
            oRed     <= bRed;
            oGreen   <= bGreen;
            oBlue    <= bBlue;
            oDVAL    <= bValid;
            oFVAL    <= bFval;
            oKeyMask <= bValid && bKey;
            if (bValid) begin
                oX_Counter <= bX;
                oY_Counter <= bY;
            end
            if (bStart) begin
                keyCnt <= CW'(bValid && bKey);
            end else if (bValid && bKey && (keyCnt != KEY_MAX)) begin
                keyCnt <= keyCnt + CW'(1);
            end
            if (bEnd) begin
                oKeyCount      <= keyCnt;
                oFrame_Counter <= oFrame_Counter + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_chroma_key_pipeline.sv
// Randomised frame-level bench for chroma_key_pipeline against a frame/pixel reference model.
module tb_chroma_key_pipeline;
    import chroma_pkg::*;

    localparam int unsigned DW = 10;
    localparam int unsigned XW = 12;
    localparam int unsigned YW = 11;
    localparam int unsigned CW = 4;
    localparam int ONES = (1 << DW) - 1;
    localparam int KMAX = (1 << CW) - 1;

    logic          iCLK = 1'b0;
    logic          iRST_N, iFVAL, iDVAL;
    logic [DW-1:0] iRed, iGreen, iBlue, iBgRed, iBgGreen, iBgBlue;
    logic [1:0]    iMode;
    logic [DW-1:0] iKeyGMin, iKeyRMargin, iKeyBMargin;
    logic [DW-1:0] oRed, oGreen, oBlue;
    logic          oDVAL, oFVAL, oKeyMask;
    logic [XW-1:0] oX_Counter;
    logic [YW-1:0] oY_Counter;
    logic [CW-1:0] oKeyCount;
    logic [31:0]   oFrame_Counter;

    always #5 iCLK = ~iCLK;

    chroma_key_pipeline #(.DW(DW), .XW(XW), .YW(YW), .CW(CW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iBgRed(iBgRed), .iBgGreen(iBgGreen), .iBgBlue(iBgBlue),
        .iMode(iMode), .iKeyGMin(iKeyGMin), .iKeyRMargin(iKeyRMargin), .iKeyBMargin(iKeyBMargin),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oDVAL(oDVAL), .oFVAL(oFVAL), .oKeyMask(oKeyMask),
        .oX_Counter(oX_Counter), .oY_Counter(oY_Counter),
        .oKeyCount(oKeyCount), .oFrame_Counter(oFrame_Counter)
    );

    typedef struct {
        bit dval, fval, key;
        int r, g, b, x, y, kc;
        int unsigned fc;
    } rec_t;

    rec_t hist[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: frame acceptance, shadowed settings, positions, statistics.
    bit          mArmed, mActive, mPrevF, mPrevValid;
    int          shMode, shBgR, shBgG, shBgB, shGMin, shRM, shBM;
    int          mX, mY, mKeys, mKeyOut, lastX, lastY;
    int unsigned mFrames;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_oRed"}, 64'(oRed), 0);
        check({tag, "_oGreen"}, 64'(oGreen), 0);
        check({tag, "_oBlue"}, 64'(oBlue), 0);
        check({tag, "_oDVAL"}, 64'(oDVAL), 0);
        check({tag, "_oFVAL"}, 64'(oFVAL), 0);
        check({tag, "_oKeyMask"}, 64'(oKeyMask), 0);
        check({tag, "_oX"}, 64'(oX_Counter), 0);
        check({tag, "_oY"}, 64'(oY_Counter), 0);
        check({tag, "_oKeyCount"}, 64'(oKeyCount), 0);
        check({tag, "_oFrame"}, 64'(oFrame_Counter), 0);
    endtask

    task automatic modelReset();
        rec_t z;
        z = '{default: 0};
        mArmed = 0; mActive = 0; mPrevF = 0; mPrevValid = 0;
        shMode = 0; shBgR = 0; shBgG = 0; shBgB = 0; shGMin = 0; shRM = 0; shBM = 0;
        mX = 0; mY = 0; mKeys = 0; mKeyOut = 0; lastX = 0; lastY = 0; mFrames = 0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
    endtask

    // One pixel clock: drive, advance the model, then compare the output due now.
    task automatic step(input bit f, input bit d, input int r, input int g, input int b);
        rec_t rec, exp;
        bit rise, fall, start, fin, valid, k;
        @(negedge iCLK);
        iFVAL = f; iDVAL = d;
        iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b);
        rise  = f && !mPrevF;
        fall  = !f && mPrevF;
        start = rise && mArmed && !mActive;
        fin   = fall && mActive;
        valid = f && d && (mActive || start);
        if (start) begin
            shMode = int'(iMode); shBgR = int'(iBgRed); shBgG = int'(iBgGreen); shBgB = int'(iBgBlue);
            shGMin = int'(iKeyGMin); shRM = int'(iKeyRMargin); shBM = int'(iKeyBMargin);
            mX = 0; mY = 0; mKeys = 0;
        end
        rec = '{default: 0};
        rec.dval = valid;
        rec.fval = f;
        if (valid) begin
            k = (g >= shGMin) && (g >= r + shRM) && (g >= b + shBM);
            rec.key = k;
            rec.r = r; rec.g = g; rec.b = b;
            if ((shMode == 1 && k) || shMode == 3) begin
                rec.r = shBgR; rec.g = shBgG; rec.b = shBgB;
            end else if (shMode == 2) begin
                rec.r = k ? ONES : 0; rec.g = k ? ONES : 0; rec.b = k ? ONES : 0;
            end
            rec.x = mX; rec.y = mY;
            mX = (mX + 1) % (1 << XW);
            if (k && mKeys < KMAX) mKeys++;
        end else begin
            rec.x = lastX; rec.y = lastY;
            if (mPrevValid && mActive) begin
                mX = 0;
                mY = (mY + 1) % (1 << YW);
            end
        end
        if (fin) begin
            mKeyOut = mKeys;
            mFrames = mFrames + 1;
        end
        if (start) mActive = 1;
        if (fin) mActive = 0;
        if (!f) mArmed = 1;
        mPrevF = f;
        mPrevValid = valid;
        lastX = rec.x; lastY = rec.y;
        rec.kc = mKeyOut;
        rec.fc = mFrames;
        hist.push_back(rec);

        @(posedge iCLK);
        #1;
        exp = hist.pop_front();
        check("oDVAL", 64'(oDVAL), 64'(exp.dval));
        check("oFVAL", 64'(oFVAL), 64'(exp.fval));
        check("oKeyMask", 64'(oKeyMask), 64'(exp.key));
        if (exp.dval) begin
            check("oRed", 64'(oRed), 64'(exp.r));
            check("oGreen", 64'(oGreen), 64'(exp.g));
            check("oBlue", 64'(oBlue), 64'(exp.b));
        end
        check("oX_Counter", 64'(oX_Counter), 64'(exp.x));
        check("oY_Counter", 64'(oY_Counter), 64'(exp.y));
        check("oKeyCount", 64'(oKeyCount), 64'(exp.kc));
        check("oFrame_Counter", 64'(oFrame_Counter), 64'(exp.fc));
    endtask

    task automatic pix(input int kind, output int r, output int g, output int b);
        if (kind == 2) begin
            r = 0; g = ONES; b = 0;
        end else if (kind == 1) begin
            r = int'($urandom_range(0, 500)); g = int'($urandom_range(500, ONES)); b = int'($urandom_range(0, 500));
        end else begin
            r = int'($urandom_range(0, ONES)); g = int'($urandom_range(0, ONES)); b = int'($urandom_range(0, ONES));
        end
    endtask

    task automatic frame(input int w, input int h, input bit riseData, input bit fallData, input int kind);
        int r, g, b, gap;
        if (!riseData) step(1, 0, 0, 0, 0);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                pix(kind, r, g, b);
                step(1, 1, r, g, b);
            end
            if (yy != h - 1 || !fallData) begin
                gap = int'($urandom_range(1, 3));
                for (int i = 0; i < gap; i++) step(1, 0, 0, 0, 0);
            end
        end
        if (fallData) begin
            pix(kind, r, g, b);
            step(0, 1, r, g, b);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic setKey(input int gmin, input int rm, input int bm, input int br, input int bg, input int bb);
        iKeyGMin = DW'(gmin); iKeyRMargin = DW'(rm); iKeyBMargin = DW'(bm);
        iBgRed = DW'(br); iBgGreen = DW'(bg); iBgBlue = DW'(bb);
    endtask

    initial begin
        int r, g, b;
        iRST_N = 1'b0; iFVAL = 1'b1; iDVAL = 1'b0;
        iRed = '0; iGreen = '0; iBlue = '0;
        iMode = MODE_COMPOSITE;
        setKey(512, 64, 64, ONES, 0, 0);
        modelReset();
        repeat (3) @(posedge iCLK);
        #1;
        checkZero("reset");
        iRST_N = 1'b1;

        // Release inside a frame: that partial frame must be ignored.
        for (int i = 0; i < 8; i++) begin
            pix(2, r, g, b);
            step(1, (i % 5) != 4, r, g, b);
        end
        step(0, 0, 0, 0, 0);
        frame(4, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("firstFrameCount", 64'(oFrame_Counter), 1);

        // Keyed and non-keyed reference pixels in composite mode.
        step(1, 0, 0, 0, 0);
        step(1, 1, 100, 700, 100);
        step(1, 1, 700, 700, 100);
        step(1, 1, 100, 511, 100);
        step(1, 1, 447, 511, 511);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Mode switched mid-frame takes effect one frame later.
        iMode = MODE_PASS;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) iMode = MODE_MATTE;
            pix(1, r, g, b);
            step(1, 1, r, g, b);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        frame(3, 2, 0, 0, 1);

        // Keyed count saturates.
        iMode = MODE_COMPOSITE;
        frame(5, 4, 0, 0, 2);
        step(0, 0, 0, 0, 0);
        check("keyCountSat", 64'(oKeyCount), 15);

        // Full-width lines, then a reset pulse mid-line.
        iMode = 2'($urandom_range(0, 3));
        frame(640, 3, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            pix(1, r, g, b);
            step(1, 1, r, g, b);
        end
        iRST_N = 1'b0;
        #1;
        checkZero("midReset");
        modelReset();
        #2;
        iRST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix(1, r, g, b);
            step(1, 1, r, g, b);
        end
        step(0, 0, 0, 0, 0);

        // Random frames, covering pixels coincident with iFVAL edges.
        for (int i = 0; i < 12; i++) begin
            iMode = 2'($urandom_range(0, 3));
            setKey(int'($urandom_range(0, ONES)), int'($urandom_range(0, 300)), int'($urandom_range(0, 300)),
                   int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)));
            frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), i[0], i[1], i % 3);
        end
        repeat (3) step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
